// File: rtl/uart_rx_framer_pkg.sv
// Shared types for the UART RX framer: FSM states, error codes and the FIFO entry layout.
package uart_rx_framer_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned ERR_W  = 2;

  typedef enum logic [1:0] {
    ST_HUNT    = 2'd0,
    ST_LEN     = 2'd1,
    ST_PAYLOAD = 2'd2,
    ST_CSUM    = 2'd3
  } state_e;

  typedef enum logic [ERR_W-1:0] {
    ERR_BADLEN  = 2'd0,
    ERR_CSUM    = 2'd1,
    ERR_OVF     = 2'd2,
    ERR_TIMEOUT = 2'd3
  } err_e;

  typedef struct packed {
    logic              last;
    logic [BYTE_W-1:0] data;
  } fifo_entry_t;

endpackage

// File: rtl/uart_rx_framer_if.sv
// Byte-input, payload-output and status signals of the UART RX framer.
interface uart_rx_framer_if;
  logic [7:0] rx_data;
  logic       rx_received;
  logic [7:0] out_data;
  logic       out_last;
  logic       out_valid;
  logic       out_ready;
  logic       frame_ok;
  logic       frame_err;
  logic [1:0] err_code;
  logic       busy;

  // master: byte source and payload consumer
  modport master (
    output rx_data, rx_received, out_ready,
    input  out_data, out_last, out_valid, frame_ok, frame_err, err_code, busy
  );

  // slave: the framer itself
  modport slave (
    input  rx_data, rx_received, out_ready,
    output out_data, out_last, out_valid, frame_ok, frame_err, err_code, busy
  );
endinterface

// File: rtl/uart_framer_fifo.sv
// Payload FIFO with speculative write pointer: pushes land speculatively and become
// visible to the reader only on commit; rollback discards everything since the last commit.
module uart_framer_fifo
  import uart_rx_framer_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        push_i,
  input  fifo_entry_t push_data_i,
  input  logic        commit_i,
  input  logic        rollback_i,
  input  logic        pop_i,
  output logic        spec_full_c,
  output logic        empty_c,
  output fifo_entry_t head_c
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  fifo_entry_t   mem_q [DEPTH];
  logic [PW-1:0] rd_q, rd_d;
  logic [PW-1:0] wr_q, wr_d;
  logic [PW-1:0] spec_q, spec_d;
  logic          do_push;
  logic          do_pop;

  assign empty_c     = (wr_q == rd_q);
  assign spec_full_c = ((spec_q - rd_q) == PW'(DEPTH));
  assign do_push     = push_i & ~spec_full_c & ~rollback_i;
  assign do_pop      = pop_i & ~empty_c;
  assign head_c      = empty_c ? '0 : mem_q[rd_q[AW-1:0]];

  // Pointer next-state; a same-cycle pop frees space only once rd_q has moved
  always_comb begin
    rd_d   = do_pop ? rd_q + PW'(1) : rd_q;
    wr_d   = commit_i ? spec_q : wr_q;
    spec_d = spec_q;
    if (rollback_i) begin
      spec_d = wr_q;
    end else if (do_push) begin
      spec_d = spec_q + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_q   <= '0;
      wr_q   <= '0;
      spec_q <= '0;
    end else begin
      rd_q   <= rd_d;
      wr_q   <= wr_d;
      spec_q <= spec_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[spec_q[AW-1:0]] <= push_data_i;
    end
  end

endmodule

// File: rtl/uart_rx_framer.sv
// Parses SYNC/LEN/payload/CSUM frames from uart_rx byte events into a commit/rollback FIFO.
// Optional inter-byte timeout enabled by defining UART_RX_FRAMER_TIMEOUT_EN.
module uart_rx_framer
  import uart_rx_framer_pkg::*;
#(
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned MAX_LEN = 8,
  parameter logic [7:0]  SYNC    = 8'hA5
`ifdef UART_RX_FRAMER_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYCLES = 100000
`endif
) (
  input  logic             clk,
  input  logic             reset_n,
  uart_rx_framer_if.slave  bus
);

  state_e      state_q, state_d;
  logic [7:0]  csum_q, csum_d;
  logic [7:0]  remain_q, remain_d;
  logic        rx_prev_q;
  logic        frame_ok_q, frame_ok_d;
  logic        frame_err_q, frame_err_d;
  logic [1:0]  err_code_q, err_code_d;
  logic        busy_q;
  logic        evt;
  logic        tmo_hit;

  logic        push_c, commit_c, rollback_c;
  fifo_entry_t push_data_c;
  logic        spec_full_c, empty_c;
  fifo_entry_t head_c;

  assign evt = bus.rx_received & ~rx_prev_q;

`ifdef UART_RX_FRAMER_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_q, tmo_d;

  // Idle counter: restarts on every byte, held at zero while hunting
  assign tmo_d   = (evt || state_q == ST_HUNT) ? '0 : tmo_q + TW'(1);
  assign tmo_hit = (state_q != ST_HUNT) && (tmo_q == TW'(TIMEOUT_CYCLES));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_d;
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  // Frame FSM: one byte per event, FIFO controls and status pulses decided here
  always_comb begin
    state_d     = state_q;
    csum_d      = csum_q;
    remain_d    = remain_q;
    frame_ok_d  = 1'b0;
    frame_err_d = 1'b0;
    err_code_d  = err_code_q;
    push_c      = 1'b0;
    commit_c    = 1'b0;
    rollback_c  = 1'b0;
    push_data_c = '{last: (remain_q == 8'd1), data: bus.rx_data};

    if (evt) begin
      unique case (state_q)
        ST_HUNT: begin
          if (bus.rx_data == SYNC) state_d = ST_LEN;
        end
        ST_LEN: begin
          if (bus.rx_data > 8'(MAX_LEN)) begin
            frame_err_d = 1'b1;
            err_code_d  = ERR_BADLEN;
            state_d     = ST_HUNT;
          end else begin
            csum_d   = bus.rx_data;
            remain_d = bus.rx_data;
            state_d  = (bus.rx_data == 8'd0) ? ST_CSUM : ST_PAYLOAD;
          end
        end
        ST_PAYLOAD: begin
          if (spec_full_c) begin
            frame_err_d = 1'b1;
            err_code_d  = ERR_OVF;
            rollback_c  = 1'b1;
            state_d     = ST_HUNT;
          end else begin
            push_c   = 1'b1;
            csum_d   = csum_q ^ bus.rx_data;
            remain_d = remain_q - 8'd1;
            if (remain_q == 8'd1) state_d = ST_CSUM;
          end
        end
        ST_CSUM: begin
          if (bus.rx_data == csum_q) begin
            commit_c   = 1'b1;
            frame_ok_d = 1'b1;
          end else begin
            frame_err_d = 1'b1;
            err_code_d  = ERR_CSUM;
            rollback_c  = 1'b1;
          end
          state_d = ST_HUNT;
        end
        default: state_d = ST_HUNT;
      endcase
    end else if (tmo_hit) begin
      frame_err_d = 1'b1;
      err_code_d  = ERR_TIMEOUT;
      rollback_c  = 1'b1;
      state_d     = ST_HUNT;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_HUNT;
      csum_q      <= '0;
      remain_q    <= '0;
      rx_prev_q   <= 1'b0;
      frame_ok_q  <= 1'b0;
      frame_err_q <= 1'b0;
      err_code_q  <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      csum_q      <= csum_d;
      remain_q    <= remain_d;
      rx_prev_q   <= bus.rx_received;
      frame_ok_q  <= frame_ok_d;
      frame_err_q <= frame_err_d;
      err_code_q  <= err_code_d;
      busy_q      <= (state_d != ST_HUNT);
    end
  end

  uart_framer_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .reset_n     (reset_n),
    .push_i      (push_c),
    .push_data_i (push_data_c),
    .commit_i    (commit_c),
    .rollback_i  (rollback_c),
    .pop_i       (bus.out_ready),
    .spec_full_c (spec_full_c),
    .empty_c     (empty_c),
    .head_c      (head_c)
  );

  assign bus.out_data  = head_c.data;
  assign bus.out_last  = head_c.last;
  assign bus.out_valid = ~empty_c;
  assign bus.frame_ok  = frame_ok_q;
  assign bus.frame_err = frame_err_q;
  assign bus.err_code  = err_code_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_uart_rx_framer.sv
// Self-checking bench for uart_rx_framer: directed frames plus randomized frames against
// a queue-based frame model. Defining UART_RX_FRAMER_TIMEOUT_EN adds the timeout scenario.
module tb_uart_rx_framer;

  localparam int unsigned DEPTH   = 16;
  localparam int unsigned MAX_LEN = 8;

  typedef logic [7:0] bq_t [$];

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_ok    = 0;
  int   n_err   = 0;
  int   n_both  = 0;
  logic [8:0] exp_q [$];

  uart_rx_framer_if bus ();

  uart_rx_framer #(
    .DEPTH   (DEPTH),
    .MAX_LEN (MAX_LEN),
    .SYNC    (8'hA5)
`ifdef UART_RX_FRAMER_TIMEOUT_EN
    , .TIMEOUT_CYCLES (50)
`endif
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.frame_ok) n_ok++;
    if (bus.frame_err) n_err++;
    if (bus.frame_ok && bus.frame_err) n_both++;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog expired before the bench completed");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.rx_data     = b;
    bus.rx_received = 1'b1;
    tick();
    tick();
    bus.rx_received = 1'b0;
    tick();
    tick();
  endtask

  // Send bytes, then check the pulse counts, error code and idle state
  task automatic frame(input string tag, input bq_t b, input int e_ok, input int e_err,
                       input logic [1:0] code);
    int ok0;
    int err0;
    ok0  = n_ok;
    err0 = n_err;
    foreach (b[i]) send_byte(b[i]);
    tick();
    chk({tag, ".ok"}, 32'(n_ok - ok0), 32'(e_ok));
    chk({tag, ".err"}, 32'(n_err - err0), 32'(e_err));
    if (e_err != 0) chk({tag, ".code"}, 32'(bus.err_code), 32'(code));
    chk({tag, ".busy"}, 32'(bus.busy), 32'd0);
    chk({tag, ".both"}, 32'(n_both), 32'd0);
  endtask

  // Frame model: outcome from LEN, committed occupancy and checksum; consumer stalled meanwhile
  task automatic model_frame(input string tag, input int len, input bq_t pl, input bit bad);
    bq_t        b;
    logic [7:0] cs;
    int         occ;
    b.push_back(8'hA5);
    b.push_back(8'(len));
    if (len > int'(MAX_LEN)) begin
      frame(tag, b, 0, 1, 2'd0);
      return;
    end
    occ = exp_q.size();
    cs  = 8'(len);
    foreach (pl[i]) cs ^= pl[i];
    if (occ + len > int'(DEPTH)) begin
      for (int i = 0; i <= int'(DEPTH) - occ; i++) b.push_back(pl[i]);
      frame(tag, b, 0, 1, 2'd2);
      return;
    end
    foreach (pl[i]) b.push_back(pl[i]);
    b.push_back(bad ? (cs ^ 8'h5A) : cs);
    frame(tag, b, bad ? 0 : 1, bad ? 1 : 0, 2'd1);
    if (!bad) foreach (pl[i]) exp_q.push_back({(i == len - 1), pl[i]});
  endtask

  function automatic bq_t rand_pl(input int len);
    bq_t q;
    for (int i = 0; i < len; i++) q.push_back(8'($urandom_range(0, 164)));
    return q;
  endfunction

  task automatic drain(input string tag);
    logic [8:0] e;
    bus.out_ready = 1'b1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk({tag, ".valid"}, 32'(bus.out_valid), 32'd1);
      chk({tag, ".data"}, 32'(bus.out_data), 32'(e[7:0]));
      chk({tag, ".last"}, 32'(bus.out_last), 32'(e[8]));
      tick();
    end
    bus.out_ready = 1'b0;
    chk({tag, ".empty"}, 32'(bus.out_valid), 32'd0);
  endtask

  initial begin
    int  ok0;
    int  err0;
    int  len;
    bq_t b;
`ifdef UART_RX_FRAMER_TIMEOUT_EN
    int  k;
`endif
    bus.rx_data     = 8'h00;
    bus.rx_received = 1'b0;
    bus.out_ready   = 1'b0;
    tick();
    tick();
    chk("rst.valid", 32'(bus.out_valid), 32'd0);
    chk("rst.busy", 32'(bus.busy), 32'd0);
    chk("rst.ok", 32'(bus.frame_ok), 32'd0);
    chk("rst.err", 32'(bus.frame_err), 32'd0);
    chk("rst.code", 32'(bus.err_code), 32'd0);
    chk("rst.data", 32'(bus.out_data), 32'd0);
    reset_n = 1'b1;
    tick();

    // Good 3-byte frame; checksum starts at LEN: 03^11^22^33 = 03
    b = {};
    b.push_back(8'hA5); b.push_back(8'h03); b.push_back(8'h11);
    b.push_back(8'h22); b.push_back(8'h33); b.push_back(8'h03);
    frame("t1", b, 1, 0, 2'd0);
    exp_q.push_back({1'b0, 8'h11});
    exp_q.push_back({1'b0, 8'h22});
    exp_q.push_back({1'b1, 8'h33});
    drain("t1");

    // Bad checksum (expected 32)
    b = {};
    b.push_back(8'hA5); b.push_back(8'h02); b.push_back(8'h10);
    b.push_back(8'h20); b.push_back(8'h31);
    frame("t2", b, 0, 1, 2'd1);
    chk("t2.novalid", 32'(bus.out_valid), 32'd0);

    // LEN above MAX_LEN, then a good single-byte frame
    b = {};
    b.push_back(8'hA5); b.push_back(8'h09);
    frame("t3a", b, 0, 1, 2'd0);
    b = {};
    b.push_back(8'hA5); b.push_back(8'h01); b.push_back(8'h7E); b.push_back(8'h7F);
    frame("t3b", b, 1, 0, 2'd0);
    exp_q.push_back({1'b1, 8'h7E});
    drain("t3");

    // SYNC value inside a frame is payload: 02^A5^A5 = 02
    b = {};
    b.push_back(8'hA5); b.push_back(8'h02); b.push_back(8'hA5);
    b.push_back(8'hA5); b.push_back(8'h02);
    frame("sync_data", b, 1, 0, 2'd0);
    exp_q.push_back({1'b0, 8'hA5});
    exp_q.push_back({1'b1, 8'hA5});
    drain("sync_data");

    // Fill the FIFO with two full frames; the third overflows on its first payload byte
    model_frame("t4a", 8, rand_pl(8), 1'b0);
    model_frame("t4b", 8, rand_pl(8), 1'b0);
    chk("t4.held", 32'(exp_q.size()), 32'd16);
    model_frame("t4c", 8, rand_pl(8), 1'b0);
    drain("t4");

`ifdef UART_RX_FRAMER_TIMEOUT_EN
    // Silence after a payload byte ends the frame after the configured idle time
    err0 = n_err;
    send_byte(8'hA5);
    send_byte(8'h04);
    bus.rx_data     = 8'h01;
    bus.rx_received = 1'b1;
    tick();
    k = 0;
    for (int c = 1; c <= 200; c++) begin
      if (c == 2) bus.rx_received = 1'b0;
      tick();
      if (bus.frame_err && k == 0) k = c;
    end
    chk("t5.window", 32'((k >= 49) && (k <= 52)), 32'd1);
    chk("t5.err", 32'(n_err - err0), 32'd1);
    chk("t5.code", 32'(bus.err_code), 32'd3);
    chk("t5.busy", 32'(bus.busy), 32'd0);
    chk("t5.novalid", 32'(bus.out_valid), 32'd0);
`else
    // Without the timeout a frame waits indefinitely: 02^11^22 = 31
    err0 = n_err;
    send_byte(8'hA5);
    send_byte(8'h02);
    send_byte(8'h11);
    for (int c = 0; c < 300; c++) tick();
    chk("wait.busy", 32'(bus.busy), 32'd1);
    chk("wait.noerr", 32'(n_err - err0), 32'd0);
    b = {};
    b.push_back(8'h22); b.push_back(8'h31);
    frame("wait", b, 1, 0, 2'd0);
    exp_q.push_back({1'b0, 8'h11});
    exp_q.push_back({1'b1, 8'h22});
    drain("wait");
`endif

    // Reset mid-payload with a committed frame pending
    model_frame("t6a", 1, rand_pl(1), 1'b0);
    send_byte(8'hA5);
    send_byte(8'h04);
    send_byte(8'h01);
    ok0  = n_ok;
    err0 = n_err;
    reset_n = 1'b0;
    #1;
    chk("t6.valid", 32'(bus.out_valid), 32'd0);
    chk("t6.busy", 32'(bus.busy), 32'd0);
    exp_q.delete();
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    chk("t6.nopulse_ok", 32'(n_ok - ok0), 32'd0);
    chk("t6.nopulse_err", 32'(n_err - err0), 32'd0);
    b = {};
    b.push_back(8'hA5); b.push_back(8'h00); b.push_back(8'h00);
    frame("t6b", b, 1, 0, 2'd0);
    chk("t6.empty", 32'(bus.out_valid), 32'd0);

    // Randomized frames: lengths around the limit, occasional bad checksum, sporadic draining
    for (int f = 0; f < 40; f++) begin
      len = int'($urandom_range(0, MAX_LEN + 1));
      model_frame($sformatf("rnd%0d", f), len, rand_pl(len), ($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 2) == 0) drain($sformatf("rnd%0d", f));
    end
    drain("final");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
